// File: rtl/adj_delay_ctrl.sv
// -----------------------------------------------------------------------------
// adj_delay_ctrl
// Run-time controller for the BRAM adjustable delay line. It accepts
// delay-change requests over a valid/ready handshake, range-checks them,
// drives the line's DELAY input and blanks dout_valid_o until the line holds
// only samples written under the new delay.
//
// States:
//   state | meaning
//   FILL  | line is refilling; counting CE samples up to target, outputs blanked
//   RUN   | line output valid; requests accepted
//
// Ports:
//   clk_i         master clock, shared with the delay line
//   rst_i         asynchronous reset, active-high
//   ce_i          sample enable, same signal as the line's CE
//   req_delay_i   requested delay in CE samples
//   req_valid_i   request valid
//   req_ready_o   request ready (high only in steady RUN)
//   delay_out_o   registered delay to the line's DELAY input
//   dout_valid_o  line output is valid for delay_out_o
//   busy_o        controller is not in steady RUN
//   err_o         one-cycle pulse on a rejected out-of-range request
//   chg_cnt_o     accepted-change count (statistics build only, else 0)
//   rej_cnt_o     rejected-request count (statistics build only, else 0)
//
// Build option: define ADJ_DELAY_CTRL_STATS_EN to build the saturating
// change/reject counters. Without it both count outputs are tied to zero.
// -----------------------------------------------------------------------------
module adj_delay_ctrl #(
    parameter int unsigned MIN_DELAY     = 4,
    parameter int unsigned MAX_DELAY     = 1024,
    parameter int unsigned DEFAULT_DELAY = 10,
    parameter int unsigned GUARD         = 2,
    parameter int unsigned ADR_SPAN      = 65536
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ce_i,
    input  logic [15:0] req_delay_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    output logic [15:0] delay_out_o,
    output logic        dout_valid_o,
    output logic        busy_o,
    output logic        err_o,
    output logic [7:0]  chg_cnt_o,
    output logic [7:0]  rej_cnt_o
);

    localparam logic [15:0] MIN_D     = 16'(MIN_DELAY);
    localparam logic [15:0] MAX_D     = 16'(MAX_DELAY);
    localparam logic [15:0] DEF_D     = 16'(DEFAULT_DELAY);
    localparam logic [16:0] GUARD_W   = 17'(GUARD);
    localparam logic [16:0] SPAN_W    = 17'(ADR_SPAN);
    localparam logic [16:0] DEF_TGT   = 17'(DEFAULT_DELAY + GUARD);

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [16:0] cnt_q, cnt_d;
    logic [16:0] target_q, target_d;
    logic [15:0] delay_q, delay_d;
    logic        valid_q, valid_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;

    logic        hs;
    logic        out_of_range;
    logic        is_up;
    logic        is_down;
    logic        change;
    logic        reject;
    logic        fill_done;
    logic        run_steady;

    // Request decode. ready_q is only ever high in steady RUN, so a handshake
    // can never land while the line is refilling.
    always_comb begin
        hs           = req_valid_i & ready_q;
        out_of_range = (req_delay_i < MIN_D) || (req_delay_i > MAX_D);
        is_up        = req_delay_i > delay_q;
        is_down      = req_delay_i < delay_q;
        change       = hs & ~out_of_range & (is_up | is_down);
        reject       = hs & out_of_range;
        fill_done    = (state_q == S_FILL) && ce_i && (cnt_q == target_q - 17'd1);
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_FILL;
            cnt_q    <= '0;
            target_q <= DEF_TGT;
            delay_q  <= DEF_D;
            valid_q  <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            delay_q  <= delay_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        delay_d  = delay_q;
        case (state_q)
            S_FILL: begin
                if (fill_done) begin
                    state_d = S_RUN;
                end else if (ce_i) begin
                    cnt_d = cnt_q + 17'd1;
                end
            end
            S_RUN: begin
                if (change) begin
                    state_d = S_FILL;
                    cnt_d   = '0;
                    delay_d = req_delay_i;
                    // A shorter delay points the read address back at samples
                    // written under the old period, so the write address has to
                    // wrap its full span before every read slot is fresh.
                    if (is_up) begin
                        target_d = {1'b0, req_delay_i} + GUARD_W;
                    end else begin
                        target_d = SPAN_W + {1'b0, req_delay_i};
                    end
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    // Outputs: entering RUN is reported one clock after the state changes,
    // leaving RUN is reported on the handshake edge itself.
    always_comb begin
        run_steady = (state_q == S_RUN) && (state_d == S_RUN);
        valid_d    = run_steady;
        ready_d    = run_steady;
        busy_d     = ~run_steady;
        err_d      = reject;
    end

    assign req_ready_o  = ready_q;
    assign delay_out_o  = delay_q;
    assign dout_valid_o = valid_q;
    assign busy_o       = busy_q;
    assign err_o        = err_q;

`ifdef ADJ_DELAY_CTRL_STATS_EN
    logic [7:0] chg_q;
    logic [7:0] rej_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            chg_q <= '0;
            rej_q <= '0;
        end else begin
            if (change && (chg_q != 8'hFF)) begin
                chg_q <= chg_q + 8'd1;
            end
            if (reject && (rej_q != 8'hFF)) begin
                rej_q <= rej_q + 8'd1;
            end
        end
    end

    assign chg_cnt_o = chg_q;
    assign rej_cnt_o = rej_q;
`else
    assign chg_cnt_o = 8'd0;
    assign rej_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_adj_delay_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adj_delay_ctrl
// Scoreboard bench for adj_delay_ctrl. Stimulus pushes expected dout_valid
// rise/fall events, err pulses and cycle snapshots into queues; a monitor
// sampling 2 time units after each rising edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_adj_delay_ctrl;

`ifdef ADJ_DELAY_CTRL_STATS_EN
    localparam int S = 1;
`else
    localparam int S = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [15:0] req_delay;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] delay_out;
    logic        dout_valid;
    logic        busy;
    logic        err;
    logic [7:0]  chg_cnt;
    logic [7:0]  rej_cnt;

    adj_delay_ctrl #(
        .MIN_DELAY     (4),
        .MAX_DELAY     (1024),
        .DEFAULT_DELAY (10),
        .GUARD         (2),
        .ADR_SPAN      (256)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ce_i         (ce),
        .req_delay_i  (req_delay),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .delay_out_o  (delay_out),
        .dout_valid_o (dout_valid),
        .busy_o       (busy),
        .err_o        (err),
        .chg_cnt_o    (chg_cnt),
        .rej_cnt_o    (rej_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Ideal delay line driven by the controller: writes a sample counter and
    // reads back the slot written delay_out samples earlier.
    logic [7:0] line_mem [0:255];
    logic [7:0] line_wa   = 8'd0;
    logic [7:0] line_dout = 8'd0;
    logic       line_chk  = 1'b0;
    always @(posedge clk) begin
        if (ce) begin
            line_mem[line_wa] <= line_wa;
            line_dout         <= line_mem[line_wa - delay_out[7:0]];
            line_wa           <= line_wa + 8'd1;
        end
    end

    typedef struct {
        string name;
        int    cyc;
        int    delay;
    } ev_t;

    typedef struct {
        string name;
        int    cyc;
        int    delay;
        int    valid;
        int    ready;
        int    busy;
        int    err;
        int    chg;
        int    rej;
    } snap_t;

    ev_t   q_rise [$];
    ev_t   q_fall [$];
    ev_t   q_err  [$];
    snap_t q_snap [$];

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic flag(input string nm);
        n_cmp++;
        n_mis++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    function automatic ev_t mk_ev(input string nm, input int c, input int d);
        ev_t e;
        e.name  = nm;
        e.cyc   = c;
        e.delay = d;
        return e;
    endfunction

    task automatic push_snap(input string nm, input int c, input int d, input int v,
                             input int rdy, input int bsy, input int e, input int chg,
                             input int rej);
        snap_t s;
        s.name = nm; s.cyc = c; s.delay = d; s.valid = v; s.ready = rdy;
        s.busy = bsy; s.err = e; s.chg = chg; s.rej = rej;
        q_snap.push_back(s);
    endtask

    // Monitor
    logic prev_valid = 1'b0;
    logic prev_err   = 1'b0;
    always begin
        ev_t   e;
        snap_t s;
        @(posedge clk);
        #2;
        while (q_snap.size() > 0 && q_snap[0].cyc <= cyc) begin
            s = q_snap.pop_front();
            if (s.cyc < cyc) begin
                flag({s.name, "_missed"});
            end else begin
                chk({s.name, "_delay"}, int'(delay_out), s.delay);
                chk({s.name, "_valid"}, int'(dout_valid), s.valid);
                chk({s.name, "_ready"}, int'(req_ready), s.ready);
                chk({s.name, "_busy"},  int'(busy), s.busy);
                chk({s.name, "_err"},   int'(err), s.err);
                chk({s.name, "_chg"},   int'(chg_cnt), s.chg);
                chk({s.name, "_rej"},   int'(rej_cnt), s.rej);
            end
        end
        if (!rst) begin
            if (dout_valid && !prev_valid) begin
                if (q_rise.size() == 0) flag("unexpected_valid_rise");
                else begin
                    e = q_rise.pop_front();
                    chk({e.name, "_rise_cyc"}, cyc, e.cyc);
                    chk({e.name, "_rise_delay"}, int'(delay_out), e.delay);
                end
            end
            if (!dout_valid && prev_valid) begin
                if (q_fall.size() == 0) flag("unexpected_valid_fall");
                else begin
                    e = q_fall.pop_front();
                    chk({e.name, "_fall_cyc"}, cyc, e.cyc);
                    chk({e.name, "_fall_delay"}, int'(delay_out), e.delay);
                end
            end
            if (err) begin
                if (prev_err) flag("err_longer_than_one_cycle");
                if (q_err.size() == 0) flag("unexpected_err");
                else begin
                    e = q_err.pop_front();
                    chk({e.name, "_err_cyc"}, cyc, e.cyc);
                    chk({e.name, "_err_delay"}, int'(delay_out), e.delay);
                    chk({e.name, "_err_valid"}, int'(dout_valid), 1);
                end
            end
            if (line_chk) begin
                chk("line_dout_delay20", int'(line_dout), int'(line_wa - 8'd21));
            end
        end
        prev_valid = dout_valid;
        prev_err   = err;
    end

    task automatic send(input int d);
        req_delay = 16'(d);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_valid(input string nm, input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (dout_valid) done = 1;
        end
        if (!done) flag({nm, "_timeout"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  c;
        int  h;
        int  r0;
        bit  done;

        rst       = 1'b1;
        ce        = 1'b1;
        req_valid = 1'b0;
        req_delay = 16'd0;
        repeat (3) @(negedge clk);

        // 1. reset values, then first fill: 12 samples + 1 clock
        push_snap("reset", cyc + 1, 10, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        r0  = cyc;
        push_snap("fill_pre", r0 + 12, 10, 0, 0, 1, 0, 0, 0);
        q_rise.push_back(mk_ev("fill_reset", r0 + 13, 10));
        wait_valid("fill_reset", 40);
        repeat (2) @(negedge clk);

        // 2. grow to 20: blank 22 samples + 1, then line output delayed by 20
        c = cyc;
        q_fall.push_back(mk_ev("up20", c + 1, 20));
        push_snap("up20_pre", c + 23, 20, 0, 0, 1, 0, S * 1, 0);
        q_rise.push_back(mk_ev("up20", c + 24, 20));
        send(20);
        wait_valid("up20", 40);
        line_chk = 1'b1;
        repeat (5) @(negedge clk);
        line_chk = 1'b0;

        // 3. shrink to 8: 256+8 = 264 samples, CE toggling -> 528 clocks + 1
        c = cyc;
        h = c + 1;
        q_fall.push_back(mk_ev("down8", h, 8));
        push_snap("down8_pre", h + 528, 8, 0, 0, 1, 0, S * 2, 0);
        q_rise.push_back(mk_ev("down8", h + 529, 8));
        send(8);
        done = 0;
        for (int k = 1; k <= 700 && !done; k++) begin
            ce = (k % 2 == 0);
            @(negedge clk);
            if (dout_valid) done = 1;
        end
        ce = 1'b1;
        if (!done) flag("down8_timeout");
        repeat (2) @(negedge clk);

        // 4. out-of-range requests 3 and 1025
        c = cyc;
        q_err.push_back(mk_ev("rej3", c + 1, 8));
        send(3);
        @(negedge clk);
        c = cyc;
        q_err.push_back(mk_ev("rej1025", c + 1, 8));
        send(1025);
        push_snap("rej_after", cyc + 1, 8, 1, 1, 0, 0, S * 2, S * 2);
        repeat (2) @(negedge clk);

        // 5. request equal to current delay is a no-op
        c = cyc;
        push_snap("noop_hs", c + 1, 8, 1, 1, 0, 0, S * 2, S * 2);
        send(8);
        push_snap("noop_after", cyc + 2, 8, 1, 1, 0, 0, S * 2, S * 2);
        repeat (3) @(negedge clk);

        // 6. reset in the middle of the fill after a request of 500
        c = cyc;
        q_fall.push_back(mk_ev("up500", c + 1, 500));
        push_snap("up500_fill", c + 3, 500, 0, 0, 1, 0, S * 3, S * 2);
        send(500);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        push_snap("mid_rst", cyc + 1, 10, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        r0  = cyc;
        push_snap("refill_pre", r0 + 12, 10, 0, 0, 1, 0, 0, 0);
        q_rise.push_back(mk_ev("refill", r0 + 13, 10));
        wait_valid("refill", 40);
        repeat (3) @(negedge clk);

        foreach (q_rise[i]) flag({q_rise[i].name, "_rise_never_seen"});
        foreach (q_fall[i]) flag({q_fall[i].name, "_fall_never_seen"});
        foreach (q_err[i])  flag({q_err[i].name, "_err_never_seen"});
        foreach (q_snap[i]) flag({q_snap[i].name, "_snapshot_not_reached"});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
